// File: rtl/count_weight.sv
// count_weight: per-block symbol frequency counter for an 8-symbol alphabet.
// Eight 4-bit counters accumulate symbol occurrences; a counter about to
// overflow triggers a ceiling-halving rescale of all counters. At block end
// the packed weight vector is held for the downstream tree generator until
// it is acknowledged.
module count_weight #(
   parameter int MIN_ONE = 1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        sym_valid,
   input  logic [2:0]  sym,
   input  logic        sym_last,
   output logic        sym_ready,
   output logic [31:0] weight_Gather,
   output logic        gather_valid,
   input  logic        gather_ack,
   output logic [3:0]  rescale_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam bit FILL_ZERO = (MIN_ONE != 0);

   state_t           state;
   logic [7:0][3:0]  cnt;
   logic [7:0][3:0]  cnt_next;
   logic [7:0][3:0]  halved;
   logic             accept;
   logic             overflow;
   logic             clear;
   logic             fill_en;

   assign accept   = sym_valid & sym_ready;
   assign overflow = (cnt[sym] == 4'hF);
   assign clear    = (state == DONE) & gather_ack;
   assign fill_en  = gather_valid & FILL_ZERO;

   // Per-lane ceiling halving and output field formatting.
   for (genvar k = 0; k < 8; k++) begin : g_lane
      logic [4:0] inc;
      assign inc       = {1'b0, cnt[k]} + 5'd1;
      assign halved[k] = inc[4:1];
      assign weight_Gather[4*k +: 4] = (fill_en && (cnt[k] == 4'd0)) ? 4'd1 : cnt[k];
   end

   // Next counter values: clear on ack, rescale-then-increment on overflow.
   always_comb begin
      cnt_next = cnt;
      if (clear) begin
         cnt_next = '0;
      end else if (accept) begin
         if (overflow) begin
            cnt_next      = halved;
            cnt_next[sym] = halved[sym] + 4'd1;
         end else begin
            cnt_next[sym] = cnt[sym] + 4'd1;
         end
      end
   end

   // Block FSM with registered handshake outputs, counters and rescale count.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= IDLE;
         sym_ready    <= 1'b1;
         gather_valid <= 1'b0;
         rescale_cnt  <= '0;
         cnt          <= '0;
      end else begin
         cnt <= cnt_next;

         if (clear) begin
            rescale_cnt <= '0;
         end else if (accept && overflow && (rescale_cnt != 4'hF)) begin
            rescale_cnt <= rescale_cnt + 4'd1;
         end

         case (state)
            IDLE, COUNT: begin
               if (accept) begin
                  if (sym_last) begin
                     state        <= DONE;
                     sym_ready    <= 1'b0;
                     gather_valid <= 1'b1;
                  end else begin
                     state <= COUNT;
                  end
               end
            end
            DONE: begin
               if (gather_ack) begin
                  state        <= IDLE;
                  sym_ready    <= 1'b1;
                  gather_valid <= 1'b0;
               end
            end
            default: begin
               state        <= IDLE;
               sym_ready    <= 1'b1;
               gather_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_count_weight.sv
// Testbench for count_weight: two instances (MIN_ONE=1 and MIN_ONE=0) share
// stimulus; a frequency-count reference model predicts live and final
// weights, and a scoreboard checks each published block.
module tb_count_weight;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        sym_valid = 1'b0;
   logic [2:0]  sym = '0;
   logic        sym_last = 1'b0;
   logic        gather_ack = 1'b0;

   logic        ready1, gv1, ready0, gv0;
   logic [31:0] w1, w0;
   logic [3:0]  rc1, rc0;

   count_weight #(.MIN_ONE(1)) dut1 (
      .CLK(CLK), .RST(RST), .sym_valid(sym_valid), .sym(sym), .sym_last(sym_last),
      .sym_ready(ready1), .weight_Gather(w1), .gather_valid(gv1),
      .gather_ack(gather_ack), .rescale_cnt(rc1)
   );

   count_weight #(.MIN_ONE(0)) dut0 (
      .CLK(CLK), .RST(RST), .sym_valid(sym_valid), .sym(sym), .sym_last(sym_last),
      .sym_ready(ready0), .weight_Gather(w0), .gather_valid(gv0),
      .gather_ack(gather_ack), .rescale_cnt(rc0)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   // Reference model: plain symbol frequencies with halving on overflow.
   int mc[8];
   int mresc = 0;
   bit mdone = 1'b0;

   typedef struct {
      logic [31:0] w1;
      logic [31:0] w0;
      int          r;
      int          edge_no;
   } exp_t;

   exp_t q[$];
   logic [2:0] blk[$];

   function automatic logic [31:0] pack_w(input bit fill);
      logic [31:0] w;
      int v;
      w = '0;
      for (int k = 0; k < 8; k++) begin
         v = mc[k];
         if (fill && v == 0) v = 1;
         w[4*k +: 4] = v[3:0];
      end
      return w;
   endfunction

   function automatic void clear_model();
      for (int k = 0; k < 8; k++) mc[k] = 0;
      mresc = 0;
      mdone = 1'b0;
   endfunction

   function automatic void model_accept(input int s);
      if (mc[s] == 15) begin
         for (int k = 0; k < 8; k++) mc[k] = (mc[k] + 1) / 2;
         if (mresc < 15) mresc++;
      end
      mc[s]++;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus, entered and left on a falling edge.
   task automatic step(input bit v, input logic [2:0] s, input bit l, input bit a);
      chk("sym_ready", 32'(ready1), 32'(!mdone));
      chk("sym_ready_m0", 32'(ready0), 32'(!mdone));
      sym_valid  = v;
      sym        = s;
      sym_last   = l;
      gather_ack = a;
      if (v && !mdone) begin
         model_accept(int'(s));
         if (l) begin
            mdone = 1'b1;
            q.push_back('{pack_w(1'b1), pack_w(1'b0), mresc, cyc + 1});
         end
      end else if (mdone && a) begin
         clear_model();
      end
      @(negedge CLK);
      chk("gather_valid", 32'(gv1), 32'(mdone));
      chk("weight_m1", w1, pack_w(mdone));
      chk("weight_m0", w0, pack_w(1'b0));
      chk("rescale_cnt", 32'(rc1), mresc);
   endtask

   task automatic send_block(input bit gaps);
      int n;
      n = blk.size();
      for (int i = 0; i < n; i++) begin
         if (gaps && ($urandom_range(3) == 0))
            step(1'b0, 3'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)));
         step(1'b1, blk[i], (i == n - 1), 1'($urandom_range(1)));
      end
      blk.delete();
   endtask

   task automatic finish_block(input int hold, input bit force_v);
      for (int h = 0; h < hold; h++)
         step(force_v | 1'($urandom_range(1)), 3'($urandom_range(7)), 1'($urandom_range(1)), 1'b0);
      step(1'b0, 3'd0, 1'b0, 1'b1);
   endtask

   task automatic push_n(input logic [2:0] s, input int n);
      for (int i = 0; i < n; i++) blk.push_back(s);
   endtask

   task automatic async_reset();
      #2 RST = 1'b1;
      #1;
      chk("rst_weight_m1", w1, 32'h0);
      chk("rst_weight_m0", w0, 32'h0);
      chk("rst_gather_valid", 32'(gv1), 32'h0);
      chk("rst_sym_ready", 32'(ready1), 32'h1);
      chk("rst_rescale", 32'(rc1), 32'h0);
      clear_model();
      q.delete();
      sym_valid = 1'b0;
      sym_last  = 1'b0;
      gather_ack = 1'b0;
      @(negedge CLK);
      RST = 1'b0;
   endtask

   // Scoreboard monitor: checks each newly published block and its hold.
   bit prev_gv = 1'b0;
   logic [31:0] held = '0;
   always @(negedge CLK) begin
      if (RST) begin
         prev_gv <= 1'b0;
      end else begin
         if (gv1 && !prev_gv) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_gather_valid actual=1 required=0 (t=%0t)", $time);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("sb_weight_m1", w1, e.w1);
               chk("sb_weight_m0", w0, e.w0);
               chk("sb_rescale", 32'(rc1), e.r);
               chk("sb_latency_edge", cyc, e.edge_no);
            end
            held <= w1;
         end else if (gv1 && prev_gv) begin
            chk("done_stable", w1, held);
         end
         prev_gv <= gv1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clear_model();
      repeat (2) @(negedge CLK);
      chk("reset_weight", w1, 32'h0);
      chk("reset_ready", 32'(ready1), 32'h1);
      chk("reset_gv", 32'(gv1), 32'h0);
      RST = 1'b0;

      // Basic count.
      push_n(3'd0, 10); push_n(3'd1, 1); push_n(3'd2, 12); push_n(3'd3, 1);
      push_n(3'd4, 11); push_n(3'd5, 2); push_n(3'd6, 13); push_n(3'd7, 3);
      send_block(1'b0);
      chk("basic_weight", w1, 32'h3D2B1C1A);
      chk("basic_rescale", 32'(rc1), 32'h0);
      finish_block(2, 1'b0);

      // Zero fill.
      push_n(3'd5, 4);
      send_block(1'b1);
      chk("zero_fill_m1", w1, 32'h11411111);
      chk("zero_fill_m0", w0, 32'h00400000);
      finish_block(1, 1'b0);

      // Overflow rescale.
      push_n(3'd0, 15); push_n(3'd1, 1); push_n(3'd0, 1);
      send_block(1'b0);
      chk("overflow_weight", w1, 32'h11111119);
      chk("overflow_rescale", 32'(rc1), 32'h1);
      finish_block(0, 1'b0);

      // Backpressure then a fresh block counted from zero.
      push_n(3'd6, 5);
      send_block(1'b0);
      finish_block(20, 1'b1);
      push_n(3'd3, 2);
      send_block(1'b0);
      chk("after_ack_weight", w1, 32'h11112111);
      finish_block(1, 1'b0);

      // Reset mid-block, then a single-symbol block.
      for (int i = 0; i < 5; i++) step(1'b1, 3'($urandom_range(7)), 1'b0, 1'b0);
      async_reset();
      push_n(3'd7, 1);
      send_block(1'b0);
      chk("single_sym_m1", w1, 32'h11111111);
      chk("single_sym_m0", w0, 32'h10000000);
      finish_block(1, 1'b0);

      // Reset while a block is pending in DONE.
      push_n(3'd2, 3);
      send_block(1'b0);
      step(1'b1, 3'd1, 1'b0, 1'b0);
      async_reset();

      // Rescale counter saturation.
      push_n(3'd0, 150); push_n(3'd4, 1);
      send_block(1'b0);
      chk("rescale_saturate", 32'(rc1), 32'hF);
      finish_block(1, 1'b0);

      // Randomized blocks, biased toward one symbol to provoke overflow.
      for (int b = 0; b < 30; b++) begin
         int n;
         logic [2:0] hot;
         n = $urandom_range(40, 1);
         hot = 3'($urandom_range(7));
         for (int i = 0; i < n; i++)
            blk.push_back(($urandom_range(3) != 0) ? hot : 3'($urandom_range(7)));
         send_block(1'b1);
         finish_block($urandom_range(5), 1'b0);
      end

      repeat (2) @(negedge CLK);
      chk("scoreboard_drained", q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/count_weight.md
COUNT_WEIGHT -- requirements
Module: count_weight

Interface
REQ-001 Parameter: MIN_ONE, default 1, forces every zero weight to 1 in the published vector (1) or leaves zero weights as 0 (0).
REQ-002 Port: CLK  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: RST  input  1  reset, asynchronous and active-high.
REQ-004 Port: sym_valid  input  1  a symbol is presented on sym.
REQ-005 Port: sym  input  3  symbol index 0..7.
REQ-006 Port: sym_last  input  1  the presented symbol is the last of the block; qualified by sym_valid.
REQ-007 Port: sym_ready  output  1  block accepts a symbol this cycle.
REQ-008 Port: weight_Gather  output  32  packed weights; bits [4k+3:4k] hold the weight of symbol k.
REQ-009 Port: gather_valid  output  1  weight_Gather is final and stable.
REQ-010 Port: gather_ack  input  1  the downstream tree generator has taken weight_Gather.
REQ-011 Port: rescale_cnt  output  4  number of rescale events in the current block, saturating at 15.

Function
REQ-012 The block SHALL implement FSM states IDLE, COUNT and DONE, encoded in 2 bits.
REQ-013 A symbol is accepted only on a cycle with sym_valid=1 and sym_ready=1; no other cycle changes any counter.
REQ-014 sym_ready SHALL be 1 in IDLE and COUNT, and 0 in DONE.
REQ-015 IDLE: all eight 4-bit counters are 0; an accepted symbol moves the FSM to COUNT, or directly to DONE if sym_last=1.
REQ-016 COUNT: an accepted symbol with sym_last=0 stays in COUNT; an accepted symbol with sym_last=1 moves to DONE on the next edge.
REQ-017 Normal accept: counter[sym] increments by 1, and the updated value is visible one cycle after the accept edge.
REQ-018 Overflow (accepted sym with counter[sym]=15), same cycle:
  - every counter c becomes (c+1)>>1 (ceiling halving, so nonzero stays nonzero);
  - counter[sym] then increments by 1, giving 9;
  - rescale_cnt increments, saturating at 15.
REQ-019 DONE: gather_valid=1 and weight_Gather holds the final counters, with zero fields replaced by 1 when MIN_ONE=1.
REQ-020 DONE: weight_Gather SHALL stay constant until leaving DONE.
REQ-021 DONE with gather_ack=1: the FSM returns to IDLE on the next edge, all counters clear to 0, and rescale_cnt clears to 0.
REQ-022 gather_ack outside DONE SHALL be ignored.
REQ-023 Outside DONE: gather_valid=0 and weight_Gather shows the live counters, with no MIN_ONE substitution.
REQ-024 sym_last with sym_valid=0 SHALL be ignored.
REQ-025 sym_valid while sym_ready=0 (DONE) SHALL not be counted; upstream must hold the symbol.
REQ-026 Latency: gather_valid rises exactly 1 cycle after the edge that accepted the sym_last symbol.

Reset
REQ-027 RST=1 SHALL asynchronously force:
  - FSM to IDLE;
  - all counters, rescale_cnt, gather_valid and weight_Gather to 0;
  - sym_ready to 1.
REQ-028 Reset asserted mid-COUNT or in DONE SHALL discard the partial or pending block with no output pulse.
REQ-029 The first accept is allowed on the first rising edge after RST deasserts.

Verification
REQ-030 Basic count, MIN_ONE=1: stream sym=0 x10, 1 x1, 2 x12, 3 x1, 4 x11, 5 x2, 6 x13, 7 x3, last on the final symbol -> gather_valid=1 one cycle later, weight_Gather=32'h3D2B1C1A, rescale_cnt=0.
REQ-031 Zero fill: stream sym=5 x4 with last -> weight_Gather=32'h11411111 (MIN_ONE=1) and 32'h00400000 (MIN_ONE=0).
REQ-032 Overflow: sym=0 x15, then sym=1 x1, then sym=0 x1 with last -> weights sym0=9, sym1=1, others 1 (MIN_ONE=1), weight_Gather=32'h11111119, rescale_cnt=1.
REQ-033 Backpressure: hold gather_ack=0 for 20 cycles while driving sym_valid=1 -> sym_ready=0, weight_Gather unchanged; then pulse gather_ack -> IDLE next cycle, and the next block counts from 0.
REQ-034 Reset mid-block: assert RST after 5 accepts -> outputs 0 immediately; after release, a 1-symbol block sym=7 with last -> weight_Gather=32'h11111111 with sym7 field=1.
REQ-035 Single-symbol block: first accept has sym_last=1 -> IDLE goes directly to DONE, gather_valid one cycle later.
